// File: rtl/ble_frame_parser_if.sv
// Byte-stream bundle between the UART receiver, the frame parser and the
// downstream payload consumer. The parser takes the slave view; whatever
// feeds it bytes and drains its payload takes the master view.
interface ble_frame_parser_if;
    logic       in_drive;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_ok;
    logic       err_pulse;
    logic [1:0] err_code;

    modport master (
        output in_drive, in_data, out_ready,
        input  out_valid, out_data, out_last, frame_ok, err_pulse, err_code
    );

    modport slave (
        input  in_drive, in_data, out_ready,
        output out_valid, out_data, out_last, frame_ok, err_pulse, err_code
    );
endinterface

// File: rtl/ble_frame_parser.sv
// BLE control-path frame parser: hunts for SOF, collects a length-prefixed
// payload, verifies an XOR checksum and replays the payload as a
// valid/ready stream. Bad frames are dropped whole with an error pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// HUNT    | idle, waiting for the start-of-frame byte
// LEN_ST  | SOF seen, next byte is the payload length
// PAYLOAD | storing payload bytes into the buffer
// CHK_ST  | next byte is the checksum
// EMIT    | checksum good, streaming the buffer out
module ble_frame_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hAA,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst,
    ble_frame_parser_if.slave bus
);

    localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TMO     = 2'b11;

    typedef enum logic [2:0] {
        HUNT,
        LEN_ST,
        PAYLOAD,
        CHK_ST,
        EMIT
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    len_q, len_nxt;
    logic [7:0]    chk_q, chk_nxt;
    // Shared index: write pointer while collecting, read pointer while emitting.
    logic [IW-1:0] idx_q, idx_nxt;
    logic [IW-1:0] idx_inc;
    logic [TW-1:0] tmo_q, tmo_nxt;
    logic          tmo_active;
    logic          tmo_hit;
    logic          wr_en;

    logic          out_valid_q, out_valid_nxt;
    logic [7:0]    out_data_q, out_data_nxt;
    logic          out_last_q, out_last_nxt;
    logic          frame_ok_q, frame_ok_nxt;
    logic          err_pulse_q, err_pulse_nxt;
    logic [1:0]    err_code_q, err_code_nxt;

    logic [7:0]    buf_mem [MAX_LEN];

    assign idx_inc    = idx_q + IW'(1);
    assign tmo_active = (state == LEN_ST) || (state == PAYLOAD) || (state == CHK_ST);
    // The inter-byte timer reloads on every strobe and only runs mid-frame,
    // so hitting zero means TIMEOUT_CYCLES idle cycles since the last byte.
    assign tmo_hit    = tmo_active && !bus.in_drive && (tmo_q == '0);
    assign tmo_nxt    = (bus.in_drive || !tmo_active) ? TMO_LOAD : (tmo_q - TW'(1));

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_code  = err_code_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_nxt     = state;
        len_nxt       = len_q;
        chk_nxt       = chk_q;
        idx_nxt       = idx_q;
        wr_en         = 1'b0;
        out_valid_nxt = out_valid_q;
        out_data_nxt  = out_data_q;
        out_last_nxt  = out_last_q;
        frame_ok_nxt  = 1'b0;
        err_pulse_nxt = 1'b0;
        err_code_nxt  = 2'b00;

        case (state)
            HUNT: begin
                if (bus.in_drive && (bus.in_data == SOF_BYTE)) begin
                    state_nxt = LEN_ST;
                end
            end

            LEN_ST: begin
                if (bus.in_drive) begin
                    if ((bus.in_data == 8'd0) || (bus.in_data > MAX_LEN_B)) begin
                        err_pulse_nxt = 1'b1;
                        err_code_nxt  = ERR_LEN;
                        state_nxt     = HUNT;
                    end else begin
                        len_nxt   = bus.in_data;
                        chk_nxt   = bus.in_data;
                        idx_nxt   = '0;
                        state_nxt = PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_TMO;
                    state_nxt     = HUNT;
                end
            end

            PAYLOAD: begin
                if (bus.in_drive) begin
                    wr_en   = 1'b1;
                    chk_nxt = chk_q ^ bus.in_data;
                    idx_nxt = idx_inc;
                    if (8'(idx_q) == (len_q - 8'd1)) begin
                        state_nxt = CHK_ST;
                    end
                end else if (tmo_hit) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_TMO;
                    state_nxt     = HUNT;
                end
            end

            CHK_ST: begin
                if (bus.in_drive) begin
                    if (bus.in_data == chk_q) begin
                        frame_ok_nxt  = 1'b1;
                        idx_nxt       = '0;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = buf_mem[0];
                        out_last_nxt  = (len_q == 8'd1);
                        state_nxt     = EMIT;
                    end else begin
                        err_pulse_nxt = 1'b1;
                        err_code_nxt  = ERR_CHK;
                        state_nxt     = HUNT;
                    end
                end else if (tmo_hit) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_TMO;
                    state_nxt     = HUNT;
                end
            end

            EMIT: begin
                // Bytes arriving while the buffer is busy cannot be stored;
                // a dropped SOF is deliberately not remembered.
                if (bus.in_drive) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_OVERRUN;
                end
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_nxt = 1'b0;
                        out_data_nxt  = 8'd0;
                        out_last_nxt  = 1'b0;
                        state_nxt     = HUNT;
                    end else begin
                        idx_nxt      = idx_inc;
                        out_data_nxt = buf_mem[idx_inc];
                        out_last_nxt = (8'(idx_inc) == (len_q - 8'd1));
                    end
                end
            end

            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // Datapath, timer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= 8'd0;
            chk_q       <= 8'd0;
            idx_q       <= '0;
            tmo_q       <= TMO_LOAD;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            len_q       <= len_nxt;
            chk_q       <= chk_nxt;
            idx_q       <= idx_nxt;
            tmo_q       <= tmo_nxt;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
            out_last_q  <= out_last_nxt;
            frame_ok_q  <= frame_ok_nxt;
            err_pulse_q <= err_pulse_nxt;
            err_code_q  <= err_code_nxt;
        end
    end

    // Payload buffer; contents are only meaningful after a full collect.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[idx_q] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_ble_frame_parser.sv
// Bench for ble_frame_parser: a frame-level model predicts pulses and the
// payload stream, one negedge process compares, and directed sequences add
// literal expectations on top.
module tb_ble_frame_parser;

    localparam int         T_CYC = 2000;
    localparam int         MAXL  = 16;
    localparam logic [7:0] SOF   = 8'hAA;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ble_frame_parser_if bus ();

    ble_frame_parser #(
        .SOF_BYTE      (SOF),
        .MAX_LEN       (MAXL),
        .TIMEOUT_CYCLES(T_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Frame-level model state.
    bit         m_inframe = 1'b0;
    logic [7:0] m_bytes[$];
    logic [7:0] exp_q[$];
    int         last_cyc = 0;
    bit         exp_err = 1'b0;
    logic [1:0] exp_code = 2'b00;
    bit         exp_ok = 1'b0;

    // Observation logs for literal checks.
    logic [7:0] out_log[$];
    bit         last_log[$];
    logic [1:0] err_log[$];
    int         err_cyc = 0;
    int         ok_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inframe = 1'b0;
        m_bytes.delete();
        exp_q.delete();
        exp_err = 1'b0;
        exp_ok  = 1'b0;
    endtask

    // Interpret one received byte at frame level: SOF, LEN, payload, CHK.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] x;
        int         n;
        last_cyc = cyc;
        if (exp_q.size() != 0) begin
            exp_err  = 1'b1;
            exp_code = 2'b00;
            return;
        end
        if (!m_inframe) begin
            if (b == SOF) begin
                m_inframe = 1'b1;
                m_bytes.delete();
            end
            return;
        end
        m_bytes.push_back(b);
        n = int'(m_bytes[0]);
        if (m_bytes.size() == 1) begin
            if (n == 0 || n > MAXL) begin
                exp_err   = 1'b1;
                exp_code  = 2'b01;
                m_inframe = 1'b0;
            end
        end else if (m_bytes.size() == n + 2) begin
            x = 8'd0;
            for (int i = 0; i <= n; i++) x = x ^ m_bytes[i];
            m_inframe = 1'b0;
            if (x == m_bytes[n+1]) begin
                exp_ok = 1'b1;
                for (int i = 1; i <= n; i++) exp_q.push_back(m_bytes[i]);
            end else begin
                exp_err  = 1'b1;
                exp_code = 2'b10;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_inframe && (cyc - last_cyc) == T_CYC) begin
            exp_err   = 1'b1;
            exp_code  = 2'b11;
            m_inframe = 1'b0;
        end
        check("err_pulse", bus.err_pulse, exp_err);
        if (exp_err && bus.err_pulse) check("err_code", bus.err_code, exp_code);
        check("frame_ok", bus.frame_ok, exp_ok);
        check("out_valid", bus.out_valid, exp_q.size() != 0);
        if (bus.out_valid && exp_q.size() != 0) begin
            check("out_data", bus.out_data, exp_q[0]);
            check("out_last", bus.out_last, exp_q.size() == 1);
            if (bus.out_ready) begin
                out_log.push_back(bus.out_data);
                last_log.push_back(bus.out_last);
                void'(exp_q.pop_front());
            end
        end
        if (bus.err_pulse) begin
            err_log.push_back(bus.err_code);
            err_cyc = cyc;
        end
        if (bus.frame_ok) ok_count++;
        exp_err = 1'b0;
        exp_ok  = 1'b0;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.in_drive = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_drive = 1'b0;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic good_frame_11_22();
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h31);
    endtask

    task automatic good_frame_01_02_03();
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h03);
    endtask

    int n0, e0, k0, t0;

    initial begin
        bus.in_drive  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_frame_ok", bus.frame_ok, 0);
        check("rst_err_pulse", bus.err_pulse, 0);
        check("rst_err_code", bus.err_code, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Good frame, ready held high.
        n0 = out_log.size(); k0 = ok_count;
        good_frame_11_22();
        idle(4);
        check("good_ok_count", ok_count - k0, 1);
        check("good_len", out_log.size() - n0, 2);
        if (out_log.size() - n0 == 2) begin
            check("good_b0", out_log[n0], 8'h11);
            check("good_b1", out_log[n0+1], 8'h22);
            check("good_last0", last_log[n0], 0);
            check("good_last1", last_log[n0+1], 1);
        end

        // Checksum error, then a good frame still parses.
        n0 = out_log.size(); e0 = err_log.size();
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h30);
        idle(3);
        check("chk_err_count", err_log.size() - e0, 1);
        if (err_log.size() > e0) check("chk_err_code", err_log[e0], 2'b10);
        check("chk_no_out", out_log.size() - n0, 0);
        k0 = ok_count;
        good_frame_11_22();
        idle(4);
        check("after_chk_ok", ok_count - k0, 1);
        check("after_chk_len", out_log.size() - n0, 2);

        // Noise in HUNT is silent; bad lengths flag 01.
        e0 = err_log.size();
        send_byte(8'h55); send_byte(8'h00);
        idle(2);
        check("noise_no_err", err_log.size() - e0, 0);
        send_byte(8'hAA); send_byte(8'h00);
        idle(2);
        check("len0_err_count", err_log.size() - e0, 1);
        if (err_log.size() > e0) check("len0_code", err_log[e0], 2'b01);
        send_byte(8'hAA); send_byte(8'h11);
        idle(2);
        check("len17_err_count", err_log.size() - e0, 2);
        if (err_log.size() > e0 + 1) check("len17_code", err_log[e0+1], 2'b01);

        // Inter-byte timeout.
        e0 = err_log.size();
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        t0 = last_cyc;
        idle(T_CYC + 5);
        check("tmo_err_count", err_log.size() - e0, 1);
        if (err_log.size() > e0) check("tmo_code", err_log[e0], 2'b11);
        check("tmo_delay", err_cyc - t0, T_CYC);

        // Backpressure and overrun during EMIT.
        bus.out_ready = 1'b0;
        n0 = out_log.size(); e0 = err_log.size();
        good_frame_01_02_03();
        idle(3);
        send_byte(8'h5A);
        idle(12);
        @(negedge clk);
        check("bp_valid", bus.out_valid, 1);
        check("bp_hold_data", bus.out_data, 8'h01);
        check("bp_hold_last", bus.out_last, 0);
        check("ovr_err_count", err_log.size() - e0, 1);
        if (err_log.size() > e0) check("ovr_code", err_log[e0], 2'b00);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        idle(6);
        check("bp_len", out_log.size() - n0, 3);
        if (out_log.size() - n0 == 3) begin
            check("bp_b0", out_log[n0], 8'h01);
            check("bp_b1", out_log[n0+1], 8'h02);
            check("bp_b2", out_log[n0+2], 8'h03);
            check("bp_last2", last_log[n0+2], 1);
            check("bp_last1", last_log[n0+1], 0);
        end

        // Async reset mid-PAYLOAD, then a clean frame.
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rstp_valid", bus.out_valid, 0);
        check("rstp_err", bus.err_pulse, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        n0 = out_log.size();
        good_frame_11_22();
        idle(4);
        check("rstp_after_len", out_log.size() - n0, 2);
        if (out_log.size() - n0 == 2) check("rstp_after_b1", out_log[n0+1], 8'h22);

        // Async reset mid-EMIT on a single-byte frame.
        bus.out_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        idle(2);
        check("rste_pre_valid", bus.out_valid, 1);
        check("rste_pre_last", bus.out_last, 1);
        check("rste_pre_data", bus.out_data, 8'h7E);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rste_valid", bus.out_valid, 0);
        check("rste_data", bus.out_data, 0);
        check("rste_last", bus.out_last, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.out_ready = 1'b1;
        n0 = out_log.size();
        good_frame_01_02_03();
        idle(5);
        check("rste_after_len", out_log.size() - n0, 3);
        if (out_log.size() - n0 == 3) check("rste_after_b2", out_log[n0+2], 8'h03);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
